// File: rtl/comm_link.sv
`timescale 1ns/1ps
// comm_link: board-to-board byte transceiver over a 6-bit toggle-handshake link.
// Outgoing bytes are sent as two nibbles, high nibble first. Each nibble is held
// on the bus for SETUP_CYCLES before the request toggle. Incoming nibbles are
// reassembled into bytes, and the ack of the low nibble is withheld while the
// receive buffer is still full, which back-pressures the peer.
//
// Ports:
//   clk_clk, reset_reset_n    clock (rising edge) and async active-low reset
//   communication_input[5:0]  [3:0] peer nibble, [4] peer request, [5] peer ack
//   communication_output[5:0] [3:0] our nibble,  [4] our request,  [5] our ack
//   tx_data/tx_valid/tx_ready byte offer; accepted on tx_valid & tx_ready
//   rx_data/rx_valid/rx_read  received byte, unread flag, consume strobe
//   tx_timeout/tx_timeout_clr sticky ack-wait timeout flag and its clear
module comm_link #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [5:0] communication_input,
  output logic [5:0] communication_output,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       tx_timeout,
  input  logic       tx_timeout_clr
);

  localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_SETUP_HI, TX_WAIT_HI, TX_SETUP_LO, TX_WAIT_LO
  } tx_state_e;

  // Synchroniser chain; stage SYNC_STAGES-1 is the only copy the logic uses.
  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [3:0] pn;
  logic       preq, pack;

  tx_state_e          tx_state_q, tx_state_d;
  logic [3:0]         tx_lo_q, tx_lo_d;
  logic [3:0]         tx_nib_q, tx_nib_d;
  logic               tx_req_q, tx_req_d;
  logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               tx_timeout_q, tx_timeout_d;
  logic               timeout_hit;

  logic       rx_phase_q, rx_phase_d;
  logic [3:0] rx_hi_q, rx_hi_d;
  logic       rx_ack_q, rx_ack_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_pending;

  always_comb begin
    sync_d[0] = communication_input;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign pn   = sync_q[SYNC_STAGES-1][3:0];
  assign preq = sync_q[SYNC_STAGES-1][4];
  assign pack = sync_q[SYNC_STAGES-1][5];

  // TX next state
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    tx_state_d  = tx_state_q;
    tx_lo_d     = tx_lo_q;
    tx_nib_d    = tx_nib_q;
    tx_req_d    = tx_req_q;
    setup_cnt_d = setup_cnt_q;
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_lo_d     = tx_data[3:0];
          tx_nib_d    = tx_data[7:4];
          setup_cnt_d = '0;
          tx_state_d  = TX_SETUP_HI;
        end
      end
      TX_SETUP_HI, TX_SETUP_LO: begin
        if (setup_cnt_q == SETUP_W'(SETUP_CYCLES - 1)) begin
          tx_req_d   = ~tx_req_q;
          to_cnt_d   = '0;
          tx_state_d = (tx_state_q == TX_SETUP_HI) ? TX_WAIT_HI : TX_WAIT_LO;
        end else begin
          setup_cnt_d = setup_cnt_q + SETUP_W'(1);
        end
      end
      TX_WAIT_HI, TX_WAIT_LO: begin
        if (pack == tx_req_q) begin
          if (tx_state_q == TX_WAIT_HI) begin
            tx_nib_d    = tx_lo_q;
            setup_cnt_d = '0;
            tx_state_d  = TX_SETUP_LO;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          // Counter saturates at the limit so the flag is set exactly once per
          // wait and a clear is not immediately undone while still stuck.
          if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    tx_timeout_d = tx_timeout_q;
    if (tx_timeout_clr) tx_timeout_d = 1'b0;
    if (timeout_hit)    tx_timeout_d = 1'b1;  // set beats a simultaneous clear
  end

  // RX next state
  assign rx_pending = (preq != rx_ack_q);

  always_comb begin
    rx_phase_d = rx_phase_q;
    rx_hi_d    = rx_hi_q;
    rx_ack_d   = rx_ack_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rx_read) rx_valid_d = 1'b0;
    if (rx_pending) begin
      if (!rx_phase_q) begin
        rx_hi_d    = pn;
        rx_ack_d   = ~rx_ack_q;
        rx_phase_d = 1'b1;
      end else if (!rx_valid_q || rx_read) begin
        // Completing overrides the read-clear above: read and load in one cycle.
        rx_data_d  = {rx_hi_q, pn};
        rx_valid_d = 1'b1;
        rx_ack_d   = ~rx_ack_q;
        rx_phase_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the synchroniser flops are reset too, so no stale peer toggle is seen after reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q       <= '0;
      tx_state_q   <= TX_IDLE;
      tx_lo_q      <= '0;
      tx_nib_q     <= '0;
      tx_req_q     <= 1'b0;
      setup_cnt_q  <= '0;
      to_cnt_q     <= '0;
      tx_timeout_q <= 1'b0;
      rx_phase_q   <= 1'b0;
      rx_hi_q      <= '0;
      rx_ack_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      tx_state_q   <= tx_state_d;
      tx_lo_q      <= tx_lo_d;
      tx_nib_q     <= tx_nib_d;
      tx_req_q     <= tx_req_d;
      setup_cnt_q  <= setup_cnt_d;
      to_cnt_q     <= to_cnt_d;
      tx_timeout_q <= tx_timeout_d;
      rx_phase_q   <= rx_phase_d;
      rx_hi_q      <= rx_hi_d;
      rx_ack_q     <= rx_ack_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign communication_output = {rx_ack_q, tx_req_q, tx_nib_q};
  assign tx_ready   = (tx_state_q == TX_IDLE);
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_timeout = tx_timeout_q;

endmodule
